// File: rtl/gpio_edge_capture.sv
// GPIO edge capture: synchronizes pins, optionally debounces them, detects
// rising/falling edges and latches enabled edges into a W1C status register
// with a level-sensitive interrupt.
module gpio_edge_capture #(
  parameter int npins    = 16,
  parameter int debounce = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [npins-1:0] pins_in,
  input  logic [1:0]       addr,
  input  logic             w_strobe,
  input  logic [npins-1:0] data_write,
  output logic [npins-1:0] data_read,
  output logic             irq
);

  logic [npins-1:0] sync0;
  logic [npins-1:0] sync1;
  logic [npins-1:0] level;
  logic [npins-1:0] prev;
  logic [npins-1:0] rise_en;
  logic [npins-1:0] fall_en;
  logic [npins-1:0] status;
  logic [npins-1:0] rise;
  logic [npins-1:0] fall;
  logic [npins-1:0] status_set;
  logic [npins-1:0] status_clr;
  logic             wr_rise_en;
  logic             wr_fall_en;
  logic             wr_status;

  // Two-flop synchronizer on every pin before any other use.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= pins_in;
      sync1 <= sync0;
    end
  end

  generate
    if (debounce == 0) begin : g_bypass
      assign level = sync1;
    end else begin : g_filter
      localparam int CW = $clog2(debounce + 1);
      localparam logic [CW-1:0] TC = CW'(debounce - 1);

      logic [CW-1:0]    cnt [npins];
      logic [npins-1:0] level_q;

      // Per-pin stability counter; the level follows sync1 only after it has
      // disagreed for debounce consecutive edges.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          level_q <= '0;
          for (int i = 0; i < npins; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < npins; i++) begin
            if (sync1[i] == level_q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == TC) begin
              level_q[i] <= sync1[i];
              cnt[i]     <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end
      end

      assign level = level_q;
    end
  endgenerate

  assign rise       = level & ~prev;
  assign fall       = ~level & prev;
  assign wr_rise_en = w_strobe && (addr == 2'b01);
  assign wr_fall_en = w_strobe && (addr == 2'b10);
  assign wr_status  = w_strobe && (addr == 2'b11);
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = wr_status ? data_write : '0;

  // Previous filtered level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= level;
  end

  // Edge-enable mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (wr_rise_en) rise_en <= data_write;
      if (wr_fall_en) fall_en <= data_write;
    end
  end

  // Sticky status with write-1-to-clear; a new event in the same cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) status <= '0;
    else        status <= (status & ~status_clr) | status_set;
  end

  // Registered read mux and interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_read <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= |status;
      case (addr)
        2'b00:   data_read <= level;
        2'b01:   data_read <= rise_en;
        2'b10:   data_read <= fall_en;
        default: data_read <= status;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_edge_capture.sv
// Bench for gpio_edge_capture: one instance without debounce, one with
// debounce=4, sharing the clock, reset and register bus.
module tb_gpio_edge_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pins0 = '0;
  logic [15:0] pins4 = '0;
  logic [1:0]  addr = '0;
  logic        w_strobe = 1'b0;
  logic [15:0] data_write = '0;
  logic [15:0] dr0;
  logic [15:0] dr4;
  logic        irq0;
  logic        irq4;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] pins;
    logic [1:0]  addr;
    logic        we;
    logic [15:0] wd;
    logic [15:0] exp_dr;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[13];

  gpio_edge_capture #(.npins(16), .debounce(0)) dut0 (
    .clk(clk), .reset(reset), .pins_in(pins0), .addr(addr),
    .w_strobe(w_strobe), .data_write(data_write),
    .data_read(dr0), .irq(irq0)
  );

  gpio_edge_capture #(.npins(16), .debounce(4)) dut4 (
    .clk(clk), .reset(reset), .pins_in(pins4), .addr(addr),
    .w_strobe(w_strobe), .data_write(data_write),
    .data_read(dr4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a;
    data_write = d;
    w_strobe = 1'b1;
    tick();
    w_strobe = 1'b0;
    data_write = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    w_strobe = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           pins     addr   we    wd       exp_dr   irq
    vecs[0]  = '{16'h0000, 2'd1, 1'b1, 16'h0001, 16'h0000, 1'b0};
    vecs[1]  = '{16'h0001, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{16'h0001, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[3]  = '{16'h0001, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{16'h0001, 2'd3, 1'b0, 16'h0000, 16'h0001, 1'b1};
    vecs[5]  = '{16'h0001, 2'd0, 1'b0, 16'h0000, 16'h0001, 1'b1};
    vecs[6]  = '{16'h0001, 2'd3, 1'b1, 16'h0001, 16'h0001, 1'b1};
    vecs[7]  = '{16'h0001, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[8]  = '{16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{16'h0000, 2'd3, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[12] = '{16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    #12;
    check("reset_dr0", dr0, 16'h0000);
    check("reset_irq0", {15'd0, irq0}, 16'h0000);
    check("reset_dr4", dr4, 16'h0000);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Rise on pin0, W1C clear, masked fall (debounce=0)
    for (int i = 0; i < 13; i++) begin
      pins0 = vecs[i].pins;
      addr = vecs[i].addr;
      w_strobe = vecs[i].we;
      data_write = vecs[i].wd;
      tick();
      check($sformatf("vec%0d_dr", i), dr0, vecs[i].exp_dr);
      check($sformatf("vec%0d_irq", i), {15'd0, irq0}, {15'd0, vecs[i].exp_irq});
    end
    w_strobe = 1'b0;
    data_write = '0;

    // Clear of status[3] in the same cycle its rise sets it
    wr(2'd1, 16'h0008);
    pins0 = 16'h0008;
    tick();
    tick();
    addr = 2'd3;
    data_write = 16'h0008;
    w_strobe = 1'b1;
    tick();
    w_strobe = 1'b0;
    data_write = '0;
    tick();
    check("setwins_status", dr0, 16'h0008);
    check("setwins_irq", {15'd0, irq0}, 16'h0001);
    tick();
    check("setwins_status2", dr0, 16'h0008);
    check("setwins_irq2", {15'd0, irq0}, 16'h0001);
    wr(2'd3, 16'h0008);
    rd(2'd3);
    check("setwins_cleared", dr0, 16'h0000);
    check("setwins_irq_off", {15'd0, irq0}, 16'h0000);

    // All pins toggle with full masks; status survives mask clear
    wr(2'd1, 16'hFFFF);
    wr(2'd2, 16'hFFFF);
    pins0 = 16'hFFF7;
    repeat (4) tick();
    rd(2'd3);
    check("all_status", dr0, 16'hFFFF);
    wr(2'd1, 16'h0000);
    wr(2'd2, 16'h0000);
    rd(2'd1);
    check("mask_rise_zero", dr0, 16'h0000);
    pins0 = 16'h0008;
    repeat (4) tick();
    rd(2'd3);
    check("all_status_kept", dr0, 16'hFFFF);
    check("all_irq_kept", {15'd0, irq0}, 16'h0001);
    wr(2'd3, 16'hFFFF);
    rd(2'd3);
    check("all_status_cleared", dr0, 16'h0000);
    check("all_irq_cleared", {15'd0, irq0}, 16'h0000);
    rd(2'd0);
    check("level_readback", dr0, 16'h0008);

    // Debounce=4: 3-cycle glitch rejected
    wr(2'd1, 16'h0020);
    addr = 2'd0;
    pins4 = 16'h0020;
    repeat (3) tick();
    pins4 = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("glitch_level%0d", i), dr4, 16'h0000);
    end
    rd(2'd3);
    check("glitch_status", dr4, 16'h0000);
    check("glitch_irq", {15'd0, irq4}, 16'h0000);

    // Debounce=4: 4-cycle pulse accepted with exact latency
    addr = 2'd0;
    pins4 = 16'h0020;
    repeat (4) tick();
    pins4 = 16'h0000;
    tick();
    check("pulse_level_k4", dr4, 16'h0000);
    tick();
    check("pulse_level_k5", dr4, 16'h0000);
    check("pulse_irq_k5", {15'd0, irq4}, 16'h0000);
    tick();
    check("pulse_level_k6", dr4, 16'h0020);
    check("pulse_irq_k6", {15'd0, irq4}, 16'h0000);
    addr = 2'd3;
    tick();
    check("pulse_status_k7", dr4, 16'h0020);
    check("pulse_irq_k7", {15'd0, irq4}, 16'h0001);
    repeat (8) tick();

    // Reset with pending status and a debounce count in progress
    wr(2'd3, 16'hFFFF);
    wr(2'd1, 16'h00F0);
    pins0 = 16'h00F8;
    repeat (4) tick();
    rd(2'd3);
    check("pre_reset_status", dr0, 16'h00F0);
    pins4 = 16'h0020;
    repeat (3) tick();
    check("pre_reset_irq", {15'd0, irq0}, 16'h0001);
    reset = 1'b0;
    #1;
    check("async_dr0", dr0, 16'h0000);
    check("async_irq0", {15'd0, irq0}, 16'h0000);
    check("async_dr4", dr4, 16'h0000);
    check("async_irq4", {15'd0, irq4}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    addr = 2'd3;
    repeat (13) tick();
    check("post_reset_status0", dr0, 16'h0000);
    check("post_reset_status4", dr4, 16'h0000);
    check("post_reset_irq0", {15'd0, irq0}, 16'h0000);
    check("post_reset_irq4", {15'd0, irq4}, 16'h0000);
    rd(2'd0);
    check("post_reset_level0", dr0, 16'h00F8);
    check("post_reset_level4", dr4, 16'h0020);
    rd(2'd1);
    check("post_reset_rise_en", dr0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
